// File: rtl/odu_chid_err_chk.sv
// Per-channel receive checker: verifies each enabled channel's counter pattern
// and reports sticky per-channel mismatch flags plus error/drop counters.
module odu_chid_err_chk #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 80,
    parameter int CHID_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NUM_CH-1:0]     enable_chid,
    input  logic [NUM_CH-1:0]     type_chid,
    input  logic                  clr_err,
    input  logic                  s_valid,
    input  logic [CHID_WIDTH-1:0] s_chid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic [NUM_CH-1:0]     error_chid,
    output logic [15:0]           err_cnt,
    output logic [15:0]           drop_cnt,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    state_t                state, state_nxt;
    logic                  start_d;
    logic [NUM_CH-1:0]     seeded;
    logic [DATA_WIDTH-1:0] exp_q [NUM_CH];
    logic                  mis_q;
    logic [CHID_WIDTH-1:0] ch_q;

    logic                  accept;
    logic                  in_range;
    logic                  hit;
    logic [CHID_WIDTH-1:0] ch_idx;
    logic [DATA_WIDTH-1:0] exp_nxt;
    logic [NUM_CH-1:0]     set_vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            start_d <= 1'b0;
        end else begin
            state   <= state_nxt;
            start_d <= start;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !start_d) state_nxt = ARM;
            ARM:     state_nxt = RUN;
            RUN:     if (!start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_ready = (state == RUN);
        busy    = (state == RUN);
    end

    // Out-of-range ids are steered to entry 0 but never qualify as a hit.
    always_comb begin
        accept   = s_valid && s_ready;
        in_range = (int'(s_chid) < NUM_CH);
        ch_idx   = in_range ? s_chid : '0;
        hit      = in_range && enable_chid[ch_idx];
        exp_nxt  = type_chid[ch_idx] ? (s_data - DATA_WIDTH'(1)) : (s_data + DATA_WIDTH'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seeded   <= '0;
            mis_q    <= 1'b0;
            ch_q     <= '0;
            drop_cnt <= '0;
            for (int i = 0; i < NUM_CH; i++) exp_q[i] <= '0;
        end else begin
            mis_q <= 1'b0;
            ch_q  <= ch_idx;
            if (state == ARM) begin
                seeded   <= '0;
                drop_cnt <= '0;
            end else if (accept) begin
                if (!hit) begin
                    if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                end else begin
                    // Always resync to received data so a single bad word costs at most two errors.
                    seeded[ch_idx] <= 1'b1;
                    exp_q[ch_idx]  <= exp_nxt;
                    mis_q          <= seeded[ch_idx] && (s_data != exp_q[ch_idx]);
                end
            end
        end
    end

    always_comb begin
        set_vec = mis_q ? ({{(NUM_CH-1){1'b0}}, 1'b1} << ch_q) : '0;
    end

    // A stage-2 set wins over a coincident clr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_chid <= '0;
            err_cnt    <= '0;
        end else if (state == ARM) begin
            error_chid <= '0;
            err_cnt    <= '0;
        end else begin
            error_chid <= (clr_err ? '0 : error_chid) | set_vec;
            if (clr_err)
                err_cnt <= {15'd0, mis_q};
            else if (mis_q && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_odu_chid_err_chk.sv
// Directed testbench for odu_chid_err_chk with hand-computed expectations.
module tb_odu_chid_err_chk;

    localparam int NUM_CH = 80;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [NUM_CH-1:0] enable_chid;
    logic [NUM_CH-1:0] type_chid;
    logic              clr_err;
    logic              s_valid;
    logic [6:0]        s_chid;
    logic [15:0]       s_data;
    logic              s_ready;
    logic [NUM_CH-1:0] error_chid;
    logic [15:0]       err_cnt;
    logic [15:0]       drop_cnt;
    logic              busy;

    int tests  = 0;
    int failed = 0;

    odu_chid_err_chk dut (
        .clk(clk), .rst(rst), .start(start), .enable_chid(enable_chid),
        .type_chid(type_chid), .clr_err(clr_err), .s_valid(s_valid),
        .s_chid(s_chid), .s_data(s_data), .s_ready(s_ready),
        .error_chid(error_chid), .err_cnt(err_cnt), .drop_cnt(drop_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [NUM_CH-1:0] bit_of(input int n);
        logic [NUM_CH-1:0] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input logic [15:0] d);
        s_valid = 1'b1;
        s_chid  = 7'(ch);
        s_data  = d;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; clr_err = 1'b0; s_valid = 1'b0; s_chid = '0; s_data = '0;
        enable_chid = bit_of(0) | bit_of(1) | bit_of(2) | bit_of(5) | bit_of(7) | bit_of(79);
        type_chid   = bit_of(79);
        tick(); tick();
        tests++;
        if ({s_ready, busy, error_chid, err_cnt, drop_cnt} !== '0) begin
            failed++;
            $display("FAIL reset_outputs: s_ready=%0b busy=%0b err=%h err_cnt=%0d drop=%0d, required all 0",
                     s_ready, busy, error_chid, err_cnt, drop_cnt);
        end
        rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        tests++;
        if (s_ready !== 1'b0 || busy !== 1'b0) begin
            failed++;
            $display("FAIL arm_cycle: s_ready=%0b busy=%0b, required 0 0", s_ready, busy);
        end
        tick();
        tests++;
        if (s_ready !== 1'b1 || busy !== 1'b1) begin
            failed++;
            $display("FAIL run_entry: s_ready=%0b busy=%0b, required 1 1", s_ready, busy);
        end
        tests++;
        if ({error_chid, err_cnt, drop_cnt} !== '0) begin
            failed++;
            $display("FAIL armed_idle_outputs: err=%h err_cnt=%0d drop=%0d, required 0", error_chid, err_cnt, drop_cnt);
        end
    endtask

    task automatic test_mismatch();
        send(5, 16'h0010);
        send(5, 16'h0011);
        send(5, 16'h0013);
        tests++;
        if (error_chid !== '0) begin
            failed++;
            $display("FAIL err_latency_early: error_chid=%h, required 0", error_chid);
        end
        tick();
        tests++;
        if (error_chid !== bit_of(5) || err_cnt !== 16'd1) begin
            failed++;
            $display("FAIL ch5_mismatch: error_chid=%h err_cnt=%0d, required %h 1", error_chid, err_cnt, bit_of(5));
        end
    endtask

    task automatic test_wrap();
        send(79, 16'h0001); send(79, 16'h0000); send(79, 16'hFFFF); send(79, 16'hFFFE);
        send(0, 16'hFFFF);  send(0, 16'h0000);
        tick(); tick();
        tests++;
        if (error_chid !== bit_of(5) || err_cnt !== 16'd1) begin
            failed++;
            $display("FAIL wrap: error_chid=%h err_cnt=%0d, required %h 1", error_chid, err_cnt, bit_of(5));
        end
    endtask

    task automatic test_drop();
        send(80, 16'h1234);
        send(3, 16'h0005);
        send(3, 16'h0099);
        tick(); tick();
        tests++;
        if (drop_cnt !== 16'd3 || error_chid[3] !== 1'b0 || err_cnt !== 16'd1) begin
            failed++;
            $display("FAIL drop: drop_cnt=%0d err3=%0b err_cnt=%0d, required 3 0 1", drop_cnt, error_chid[3], err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d1 [4];
        logic [15:0] d2 [4];
        d1 = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
        d2 = '{16'h0200, 16'h0201, 16'h02FF, 16'h0203};
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tests++;
        if (error_chid !== '0 || err_cnt !== 16'd0) begin
            failed++;
            $display("FAIL clr_err: error_chid=%h err_cnt=%0d, required 0 0", error_chid, err_cnt);
        end
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_chid = 7'd1; s_data = d1[i]; tick();
            s_chid = 7'd2; s_data = d2[i]; tick();
        end
        s_valid = 1'b0;
        tick();
        tests++;
        if (error_chid !== bit_of(2) || err_cnt !== 16'd2) begin
            failed++;
            $display("FAIL back_to_back: error_chid=%h err_cnt=%0d, required %h 2", error_chid, err_cnt, bit_of(2));
        end
    endtask

    task automatic test_clr_coincident();
        send(7, 16'h0050);
        send(7, 16'h0060);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tests++;
        if (error_chid !== bit_of(7) || err_cnt !== 16'd1) begin
            failed++;
            $display("FAIL clr_vs_set: error_chid=%h err_cnt=%0d, required %h 1", error_chid, err_cnt, bit_of(7));
        end
    endtask

    task automatic test_exit_run();
        start = 1'b0;
        send(7, 16'h0070);
        tests++;
        if (s_ready !== 1'b0 || busy !== 1'b0) begin
            failed++;
            $display("FAIL exit_run: s_ready=%0b busy=%0b, required 0 0", s_ready, busy);
        end
        tick();
        tests++;
        if (err_cnt !== 16'd2) begin
            failed++;
            $display("FAIL inflight_complete: err_cnt=%0d, required 2", err_cnt);
        end
        send(80, 16'h0000);
        tick();
        tests++;
        if (drop_cnt !== 16'd3) begin
            failed++;
            $display("FAIL idle_no_accept: drop_cnt=%0d, required 3", drop_cnt);
        end
    endtask

    task automatic test_rearm();
        start = 1'b1;
        tick();
        tick();
        tests++;
        if (error_chid !== '0 || err_cnt !== 16'd0 || drop_cnt !== 16'd0 || s_ready !== 1'b1) begin
            failed++;
            $display("FAIL rearm_clear: err=%h err_cnt=%0d drop=%0d s_ready=%0b, required 0 0 0 1",
                     error_chid, err_cnt, drop_cnt, s_ready);
        end
        send(5, 16'h0099);
        send(5, 16'h009A);
        tick();
        tests++;
        if (error_chid !== '0 || err_cnt !== 16'd0) begin
            failed++;
            $display("FAIL reseed: error_chid=%h err_cnt=%0d, required 0 0", error_chid, err_cnt);
        end
    endtask

    task automatic test_reset_midrun();
        send(5, 16'h0000);
        tick();
        tests++;
        if (err_cnt !== 16'd1) begin
            failed++;
            $display("FAIL pre_reset_err: err_cnt=%0d, required 1", err_cnt);
        end
        s_valid = 1'b1; s_chid = 7'd80; s_data = 16'h0;
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({s_ready, busy, error_chid, err_cnt, drop_cnt} !== '0) begin
            failed++;
            $display("FAIL async_reset: s_ready=%0b busy=%0b err=%h err_cnt=%0d drop=%0d, required all 0",
                     s_ready, busy, error_chid, err_cnt, drop_cnt);
        end
        s_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mismatch();
        test_wrap();
        test_drop();
        test_back_to_back();
        test_clr_coincident();
        test_exit_run();
        test_rearm();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
